// File: rtl/sirv_wdog_icb_regs_pkg.sv
// Shared watchdog register map, core magic values and the register index used by the decoder.
// Offsets are byte offsets from the block base.
package sirv_wdog_icb_regs_pkg;
  localparam logic [11:0] WDOG_CFG_OFS     = 12'h000;
  localparam logic [11:0] WDOG_COUNTLO_OFS = 12'h008;
  localparam logic [11:0] WDOG_COUNTHI_OFS = 12'h00C;
  localparam logic [11:0] WDOG_S_OFS       = 12'h010;
  localparam logic [11:0] WDOG_FEED_OFS    = 12'h018;
  localparam logic [11:0] WDOG_KEY_OFS     = 12'h01C;
  localparam logic [11:0] WDOG_CMP0_OFS    = 12'h020;

  localparam logic [31:0] WDOG_FEED_MAGIC = 32'h0D09F00D;
  localparam logic [31:0] WDOG_KEY_MAGIC  = 32'h0051F15E;

  localparam int WDOG_NREGS = 7;

  typedef enum logic [2:0] {
    REG_CFG     = 3'd0,
    REG_COUNTLO = 3'd1,
    REG_COUNTHI = 3'd2,
    REG_S       = 3'd3,
    REG_FEED    = 3'd4,
    REG_KEY     = 3'd5,
    REG_CMP0    = 3'd6
  } wdog_reg_e;

  function automatic logic [11:0] wdog_reg_ofs(input wdog_reg_e r);
    case (r)
      REG_CFG:     wdog_reg_ofs = WDOG_CFG_OFS;
      REG_COUNTLO: wdog_reg_ofs = WDOG_COUNTLO_OFS;
      REG_COUNTHI: wdog_reg_ofs = WDOG_COUNTHI_OFS;
      REG_S:       wdog_reg_ofs = WDOG_S_OFS;
      REG_FEED:    wdog_reg_ofs = WDOG_FEED_OFS;
      REG_KEY:     wdog_reg_ofs = WDOG_KEY_OFS;
      default:     wdog_reg_ofs = WDOG_CMP0_OFS;
    endcase
  endfunction
endpackage

// File: rtl/sirv_wdog_icb_dec.sv
// Combinational address decode: one-hot register select plus hit flag.
// Exact offset match, so misaligned byte addresses miss every register.
module sirv_wdog_icb_dec
  import sirv_wdog_icb_regs_pkg::*;
#(
  parameter int             AW   = 12,
  parameter logic [AW-1:0]  BASE = '0
) (
  input  logic [AW-1:0]          addr,
  output logic [WDOG_NREGS-1:0]  sel,
  output logic                   hit
);
  logic [AW-1:0] ofs;

  always_comb begin
    ofs = addr - BASE;
    sel = '0;
    for (int i = 0; i < WDOG_NREGS; i++) begin
      if (ofs == AW'(wdog_reg_ofs(wdog_reg_e'(i)))) sel[i] = 1'b1;
    end
    hit = |sel;
  end
endmodule

// File: rtl/sirv_wdog_icb_regs.sv
// ICB slave front-end for the watchdog core: one outstanding command, strobe and response 1 cycle after handshake.
// Response is held under rsp back-pressure; a new command is taken in the same cycle the old response drains.
module sirv_wdog_icb_regs
  import sirv_wdog_icb_regs_pkg::*;
#(
  parameter int             AW   = 12,
  parameter logic [AW-1:0]  BASE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_icb_cmd_valid,
  output logic          i_icb_cmd_ready,
  input  logic [AW-1:0] i_icb_cmd_addr,
  input  logic          i_icb_cmd_read,
  input  logic [31:0]   i_icb_cmd_wdata,
  input  logic [3:0]    i_icb_cmd_wmask,
  output logic          i_icb_rsp_valid,
  input  logic          i_icb_rsp_ready,
  output logic [31:0]   i_icb_rsp_rdata,
  output logic          i_icb_rsp_err,
  output logic          wdog_cfg_write_valid,
  output logic [31:0]   wdog_cfg_write_bits,
  input  logic [31:0]   wdog_cfg_read,
  output logic          wdog_countLo_write_valid,
  output logic [31:0]   wdog_countLo_write_bits,
  input  logic [31:0]   wdog_countLo_read,
  output logic          wdog_countHi_write_valid,
  output logic [31:0]   wdog_countHi_write_bits,
  input  logic [31:0]   wdog_countHi_read,
  output logic          wdog_s_write_valid,
  output logic [15:0]   wdog_s_write_bits,
  input  logic [15:0]   wdog_s_read,
  output logic          wdog_cmp_0_write_valid,
  output logic [15:0]   wdog_cmp_0_write_bits,
  input  logic [15:0]   wdog_cmp_0_read,
  output logic          wdog_feed_write_valid,
  output logic [31:0]   wdog_feed_write_bits,
  input  logic [31:0]   wdog_feed_read,
  output logic          wdog_key_write_valid,
  output logic [31:0]   wdog_key_write_bits,
  input  logic [31:0]   wdog_key_read
);
  typedef enum logic {ST_IDLE, ST_RESP} state_e;

  state_e                 state_q, state_d;
  logic [WDOG_NREGS-1:0]  sel, stb_q, stb_d;
  logic                   hit, hs, wr_ok;
  logic [31:0]            wdata_q, wdata_d, rdata_q, rdata_d, rd_mux;
  logic                   err_q, err_d;
  logic [31:0]            rd_vals [WDOG_NREGS];

  sirv_wdog_icb_dec #(.AW(AW), .BASE(BASE)) u_dec (
    .addr (i_icb_cmd_addr),
    .sel  (sel),
    .hit  (hit)
  );

  assign i_icb_rsp_valid = (state_q == ST_RESP);
  assign i_icb_cmd_ready = (state_q == ST_IDLE) | i_icb_rsp_ready;
  assign hs              = i_icb_cmd_valid & i_icb_cmd_ready;
  assign wr_ok           = hit & ~i_icb_cmd_read & (i_icb_cmd_wmask == 4'hF);

  always_comb begin
    rd_vals[REG_CFG]     = wdog_cfg_read;
    rd_vals[REG_COUNTLO] = wdog_countLo_read;
    rd_vals[REG_COUNTHI] = wdog_countHi_read;
    rd_vals[REG_S]       = {16'h0, wdog_s_read};
    rd_vals[REG_FEED]    = wdog_feed_read;
    rd_vals[REG_KEY]     = wdog_key_read;
    rd_vals[REG_CMP0]    = {16'h0, wdog_cmp_0_read};
    rd_mux = '0;
    for (int i = 0; i < WDOG_NREGS; i++) begin
      if (sel[i]) rd_mux = rd_mux | rd_vals[i];
    end
  end

  // Read data is captured only at the handshake, so later core changes or strobes cannot disturb it.
  always_comb begin
    state_d = state_q;
    stb_d   = '0;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (hs) begin
      state_d = ST_RESP;
      rdata_d = i_icb_cmd_read ? rd_mux : 32'h0;
      err_d   = i_icb_cmd_read ? ~hit : ~wr_ok;
      if (wr_ok) begin
        stb_d   = sel;
        wdata_d = i_icb_cmd_wdata;
      end
    end else if (i_icb_rsp_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stb_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign i_icb_rsp_rdata = rdata_q;
  assign i_icb_rsp_err   = err_q;

  assign wdog_cfg_write_valid     = stb_q[REG_CFG];
  assign wdog_countLo_write_valid = stb_q[REG_COUNTLO];
  assign wdog_countHi_write_valid = stb_q[REG_COUNTHI];
  assign wdog_s_write_valid       = stb_q[REG_S];
  assign wdog_feed_write_valid    = stb_q[REG_FEED];
  assign wdog_key_write_valid     = stb_q[REG_KEY];
  assign wdog_cmp_0_write_valid   = stb_q[REG_CMP0];

  assign wdog_cfg_write_bits     = wdata_q;
  assign wdog_countLo_write_bits = wdata_q;
  assign wdog_countHi_write_bits = wdata_q;
  assign wdog_s_write_bits       = wdata_q[15:0];
  assign wdog_feed_write_bits    = wdata_q;
  assign wdog_key_write_bits     = wdata_q;
  assign wdog_cmp_0_write_bits   = wdata_q[15:0];
endmodule

// File: tb/tb_sirv_wdog_icb_regs.sv
// Bench for sirv_wdog_icb_regs: transaction-level model checked every cycle, plus directed literal checks.
module tb_sirv_wdog_icb_regs;
  import sirv_wdog_icb_regs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_read = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wmask = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  logic        cfg_v, countlo_v, counthi_v, s_v, feed_v, key_v, cmp0_v;
  logic [31:0] cfg_b, countlo_b, counthi_b, feed_b, key_b;
  logic [15:0] s_b, cmp0_b;
  logic [31:0] cfg_rd = '0, countlo_rd = '0, counthi_rd = '0, feed_rd = '0, key_rd = '0;
  logic [15:0] s_rd = '0, cmp0_rd = '0;

  int n_checks = 0, n_errors = 0;
  int rdy_mode = 1;   // 0 random, 1 always ready, 2 stalled
  bit core_rand = 1'b0;

  // Register table in map order: cfg, countLo, countHi, s, feed, key, cmp_0
  int ofs_tab [7] = '{'h00, 'h08, 'h0C, 'h10, 'h18, 'h1C, 'h20};
  logic [11:0] err_addr [3] = '{12'h004, 12'h009, 12'h000};
  logic [3:0]  err_mask [3] = '{4'hF, 4'hF, 4'h3};

  logic [6:0] stb_vec;
  assign stb_vec = {cmp0_v, key_v, feed_v, s_v, counthi_v, countlo_v, cfg_v};

  always #5 clk = ~clk;

  sirv_wdog_icb_regs dut (
    .clk(clk), .rst_n(rst_n),
    .i_icb_cmd_valid(cmd_valid), .i_icb_cmd_ready(cmd_ready), .i_icb_cmd_addr(cmd_addr),
    .i_icb_cmd_read(cmd_read), .i_icb_cmd_wdata(cmd_wdata), .i_icb_cmd_wmask(cmd_wmask),
    .i_icb_rsp_valid(rsp_valid), .i_icb_rsp_ready(rsp_ready), .i_icb_rsp_rdata(rsp_rdata),
    .i_icb_rsp_err(rsp_err),
    .wdog_cfg_write_valid(cfg_v), .wdog_cfg_write_bits(cfg_b), .wdog_cfg_read(cfg_rd),
    .wdog_countLo_write_valid(countlo_v), .wdog_countLo_write_bits(countlo_b), .wdog_countLo_read(countlo_rd),
    .wdog_countHi_write_valid(counthi_v), .wdog_countHi_write_bits(counthi_b), .wdog_countHi_read(counthi_rd),
    .wdog_s_write_valid(s_v), .wdog_s_write_bits(s_b), .wdog_s_read(s_rd),
    .wdog_cmp_0_write_valid(cmp0_v), .wdog_cmp_0_write_bits(cmp0_b), .wdog_cmp_0_read(cmp0_rd),
    .wdog_feed_write_valid(feed_v), .wdog_feed_write_bits(feed_b), .wdog_feed_read(feed_rd),
    .wdog_key_write_valid(key_v), .wdog_key_write_bits(key_b), .wdog_key_read(key_rd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int find_reg(input logic [11:0] a);
    for (int k = 0; k < 7; k++) if (int'(a) == ofs_tab[k]) return k;
    return -1;
  endfunction

  function automatic logic [31:0] core_val(input int k);
    case (k)
      0: return cfg_rd;
      1: return countlo_rd;
      2: return counthi_rd;
      3: return {16'h0, s_rd};
      4: return feed_rd;
      5: return key_rd;
      default: return {16'h0, cmp0_rd};
    endcase
  endfunction

  function automatic logic [31:0] bits_of(input int k);
    case (k)
      0: return cfg_b;
      1: return countlo_b;
      2: return counthi_b;
      3: return {16'h0, s_b};
      4: return feed_b;
      5: return key_b;
      default: return {16'h0, cmp0_b};
    endcase
  endfunction

  // rsp_ready is owned by this process only.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       rsp_ready = 1'($urandom_range(0, 1));
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Model state: one outstanding response, at most one strobe per accepted good write.
  bit          m_pend, m_err, m_any_wr, m_hs;
  int          m_stb, m_idx;
  logic [31:0] m_rdata, m_bits, m_allbits;

  initial begin
    m_pend = 0; m_err = 0; m_any_wr = 0; m_stb = -1; m_rdata = '0; m_bits = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_pend = 0; m_err = 0; m_any_wr = 0; m_stb = -1; m_rdata = '0;
      end else begin
        chk("rsp_valid", 32'(rsp_valid), 32'(m_pend));
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_pend || rsp_ready));
        if (m_pend) begin
          chk("rsp_rdata", rsp_rdata, m_rdata);
          chk("rsp_err", 32'(rsp_err), 32'(m_err));
        end
        chk("strobes", 32'(stb_vec), (m_stb >= 0) ? (32'd1 << m_stb) : 32'd0);
        if (m_stb >= 0) chk("write_bits", bits_of(m_stb), m_bits);
        if (!m_any_wr) begin
          m_allbits = cfg_b | countlo_b | counthi_b | feed_b | key_b | {16'h0, s_b | cmp0_b};
          chk("bits_after_reset", m_allbits, 32'h0);
        end
        m_hs  = cmd_valid && (!m_pend || rsp_ready);
        m_stb = -1;
        if (m_hs) begin
          m_idx = find_reg(cmd_addr);
          m_pend = 1;
          if (cmd_read) begin
            m_err   = (m_idx < 0);
            m_rdata = (m_idx < 0) ? 32'h0 : core_val(m_idx);
          end else begin
            m_rdata = 32'h0;
            m_err   = !(m_idx >= 0 && cmd_wmask == 4'hF);
            if (!m_err) begin
              m_stb    = m_idx;
              m_bits   = (m_idx == 3 || m_idx == 6) ? {16'h0, cmd_wdata[15:0]} : cmd_wdata;
              m_any_wr = 1;
            end
          end
        end else if (m_pend && rsp_ready) begin
          m_pend = 0;
        end
      end
    end
  end

  task automatic randomize_core();
    cfg_rd = $urandom; countlo_rd = $urandom; counthi_rd = $urandom; s_rd = 16'($urandom);
    feed_rd = $urandom; key_rd = $urandom; cmp0_rd = 16'($urandom);
  endtask

  task automatic sync();
    @(posedge clk); #1;
    if (core_rand) randomize_core();
  endtask

  // Presents a command and returns just after the edge that accepted it.
  task automatic send(input bit rd, input logic [11:0] a, input logic [31:0] wd, input logic [3:0] wm);
    bit got;
    got = 1'b0;
    cmd_valid = 1'b1; cmd_read = rd; cmd_addr = a; cmd_wdata = wd; cmd_wmask = wm;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = cmd_ready;
      sync();
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL handshake_timeout: addr %h not accepted within 200 cycles", a);
      cmd_valid = 1'b0;
    end
  endtask

  initial begin
    int rsel;
    logic [11:0] ra;
    logic [3:0]  rm;

    cfg_rd = 32'hA5A5_0001;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_rsp_err", 32'(rsp_err), 32'h0);
    chk("reset_strobes", 32'(stb_vec), 32'h0);

    // Key write: strobe and error-free response in the cycle after the handshake.
    sync();
    send(1'b0, 12'h01C, WDOG_KEY_MAGIC, 4'hF);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("key_stb", 32'(stb_vec), 32'h20);
    chk("key_bits", key_b, 32'h0051F15E);
    chk("key_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("key_rsp_err", 32'(rsp_err), 32'h0);
    @(negedge clk);
    chk("key_stb_once", 32'(stb_vec), 32'h0);

    // cmp_0 read held under back-pressure while another command waits.
    rdy_mode = 2;
    cmp0_rd = 16'hFFFF;
    sync(); sync();
    send(1'b1, 12'h020, 32'h0, 4'hF);
    cmd_read = 1'b1; cmd_addr = 12'h010;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("cmp0_rdata_held", rsp_rdata, 32'h0000FFFF);
      chk("cmp0_no_ready", 32'(cmd_ready), 32'h0);
      #1 cmp0_rd = 16'h1234;
    end
    rdy_mode = 1;
    sync();
    send(1'b1, 12'h010, 32'h0, 4'hF);
    cmd_valid = 1'b0;

    // Back-to-back feed write then cfg read.
    sync(); sync();
    send(1'b0, 12'h018, WDOG_FEED_MAGIC, 4'hF);
    cmd_read = 1'b1; cmd_addr = 12'h000;
    @(negedge clk);
    chk("feed_stb", 32'(stb_vec), 32'h10);
    chk("feed_bits", feed_b, 32'h0D09F00D);
    chk("b2b_cmd_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("b2b_no_strobe", 32'(stb_vec), 32'h0);
    chk("b2b_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("cfg_rdata", rsp_rdata, 32'hA5A5_0001);

    // Unmapped, misaligned and partial-mask writes.
    for (int e = 0; e < 3; e++) begin
      sync();
      send(1'b0, err_addr[e], 32'hDEAD_BEEF, err_mask[e]);
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("bad_write_err", 32'(rsp_err), 32'h1);
      chk("bad_write_no_stb", 32'(stb_vec), 32'h0);
    end

    // countLo changes right after the handshake; the captured value must win.
    countlo_rd = 32'h1111_2222;
    sync();
    send(1'b1, 12'h008, 32'h0, 4'hF);
    cmd_valid = 1'b0;
    #1 countlo_rd = 32'h3333_4444;
    @(negedge clk);
    chk("countlo_rdata", rsp_rdata, 32'h1111_2222);

    // Reset with a response and strobe outstanding.
    rdy_mode = 2;
    sync(); sync();
    send(1'b0, 12'h000, 32'hCAFE_0001, 4'hF);
    cmd_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_strobes", 32'(stb_vec), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rdy_mode = 1;
    @(negedge clk);
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
    chk("post_rst_key_bits", key_b, 32'h0);
    chk("post_rst_cfg_bits", cfg_b, 32'h0);

    // Random traffic against the model.
    rdy_mode = 0;
    core_rand = 1'b1;
    sync();
    for (int n = 0; n < 1500; n++) begin
      rsel = $urandom_range(0, 9);
      ra = (rsel < 7) ? 12'(ofs_tab[rsel]) : 12'($urandom_range(0, 63));
      rm = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      send(1'($urandom_range(0, 1)), ra, $urandom, rm);
      if ($urandom_range(0, 2) == 0) begin
        cmd_valid = 1'b0;
        repeat ($urandom_range(1, 3)) sync();
      end
    end
    cmd_valid = 1'b0;
    rdy_mode = 1;
    repeat (4) sync();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
